// File: rtl/approx_seq_mul.sv
// Sequential shift-and-add unsigned multiplier. Each iteration's row add uses
// OR-based approximate cells in the low APPROX_BITS positions and exact full adders above them.
module approx_seq_mul #(
  parameter int N           = 8,
  parameter int APPROX_BITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   product
);

  localparam int CW = $clog2(N);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t          state;
  logic [N-1:0]    a_reg;
  logic [N-1:0]    b_reg;
  logic [2*N-1:0]  acc;
  logic [CW-1:0]   cnt;

  logic [N-1:0]    pp;
  logic [N-1:0]    row_x;
  logic [N:0]      row_sum;
  logic [N:0]      carry;
  logic [2*N-1:0]  acc_next;

  assign pp    = b_reg[0] ? a_reg : '0;
  assign row_x = acc[2*N-1:N];

  // carry[i] enters cell i. Approximate cells pass a zero carry upward.
  // Only the topmost approximate cell produces a carry, using a plain AND of its inputs.
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_row
    if (i < APPROX_BITS) begin : g_approx
      assign row_sum[i]  = row_x[i] | pp[i];
      assign carry[i+1]  = (i == APPROX_BITS - 1) ? (row_x[i] & pp[i]) : carry[i];
    end else begin : g_exact
      assign row_sum[i]  = row_x[i] ^ pp[i] ^ carry[i];
      assign carry[i+1]  = (row_x[i] & pp[i]) | (carry[i] & (row_x[i] ^ pp[i]));
    end
  end

  assign row_sum[N] = carry[N];
  assign acc_next   = {row_sum, acc[N-1:1]};

  // NOTE: sequential state uses non-blocking assignments only. Every register is
  // cleared by the asynchronous reset, so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          b_reg <= b_reg >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            product <= acc_next;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_seq_mul.sv
// Self-checking bench: runs an exact instance and an approximate instance on shared stimulus.
// A cycle-level scoreboard checks busy, done and product on every falling edge.
module tb_approx_seq_mul;

  localparam int N = 8;
  localparam int K = 2;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic [N-1:0]   a     = '0;
  logic [N-1:0]   b     = '0;

  logic           busy_x, done_x;
  logic [2*N-1:0] product_x;
  logic           busy_a, done_a;
  logic [2*N-1:0] product_a;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  approx_seq_mul #(.N(N), .APPROX_BITS(0)) dut_exact (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy_x), .done(done_x), .product(product_x)
  );

  approx_seq_mul #(.N(N), .APPROX_BITS(K)) dut_approx (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy_a), .done(done_a), .product(product_a)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Row add written arithmetically: OR the low k bits, then add the upper slices with the
  // carry taken from bit k-1.
  function automatic int model_add(input int x, input int y, input int k);
    int low, c;
    if (k == 0) return x + y;
    low = (x | y) & ((1 << k) - 1);
    c   = (x >> (k - 1)) & (y >> (k - 1)) & 1;
    return (((x >> k) + (y >> k) + c) << k) | low;
  endfunction

  function automatic int model_mul(input int aa, input int bb, input int k);
    int acc, p, s;
    acc = 0;
    for (int i = 0; i < N; i++) begin
      p   = ((bb >> i) & 1) != 0 ? aa : 0;
      s   = model_add(acc >> N, p, k);
      acc = (s << (N - 1)) | ((acc & ((1 << N) - 1)) >> 1);
    end
    return acc & ((1 << (2 * N)) - 1);
  endfunction

  // Scoreboard timing model: push on acceptance, signal completion N edges later.
  int q_x[$];
  int q_a[$];
  int m_cnt    = 0;
  bit m_done   = 1'b0;
  int m_prod_x = 0;
  int m_prod_a = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt    = 0;
      m_done   = 1'b0;
      m_prod_x = 0;
      m_prod_a = 0;
      q_x.delete();
      q_a.delete();
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) m_done = 1'b1;
      end else if (start) begin
        q_x.push_back(model_mul(int'(a), int'(b), 0));
        q_a.push_back(model_mul(int'(a), int'(b), K));
        m_cnt = N;
      end
    end
  end

  int cyc         = 0;
  int last_done   = -1;
  bit chk_period  = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (m_done) begin
      if (q_x.size() == 0 || q_a.size() == 0) check("sb_underflow", 32'd0, 32'd1);
      else begin
        m_prod_x = q_x.pop_front();
        m_prod_a = q_a.pop_front();
      end
    end
    check("busy_x", 32'(busy_x), 32'(m_cnt > 0));
    check("busy_a", 32'(busy_a), 32'(m_cnt > 0));
    check("done_x", 32'(done_x), 32'(m_done));
    check("done_a", 32'(done_a), 32'(m_done));
    check("product_x", 32'(product_x), m_prod_x);
    check("product_a", 32'(product_a), m_prod_a);
    check("busy_done_excl", 32'(busy_a & done_a), 32'd0);
    if (done_a) begin
      if (chk_period && last_done >= 0) check("done_period", cyc - last_done, N + 1);
      last_done = cyc;
    end
  end

  task automatic run_op(input logic [N-1:0] aa, input logic [N-1:0] bb);
    int lat;
    @(posedge clk); #1;
    a = aa; b = bb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done_x && lat < 4 * N) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat - 1, N);
  endtask

  initial begin
    int pulses, guard;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_product", 32'(product_a), 32'd0);

    run_op(8'd13, 8'd11);
    check("exact_13x11", 32'(product_x), 32'd143);
    run_op(8'd255, 8'd255);
    check("exact_255x255", 32'(product_x), 32'd65025);
    run_op(8'd3, 8'd3);
    check("exact_3x3", 32'(product_x), 32'd9);
    check("approx_3x3", 32'(product_a), 32'd7);
    run_op(8'd0, 8'd200);
    check("approx_0x200", 32'(product_a), 32'd0);
    check("exact_0x200", 32'(product_x), 32'd0);
    for (int i = 0; i < 16; i++) run_op(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)));

    // Hold start high; operands scramble while busy and are restored in each done cycle.
    @(posedge clk); #1;
    a = 8'd3; b = 8'd1; start = 1'b1;
    chk_period = 1'b1;
    last_done  = -1;
    pulses = 0;
    guard  = 0;
    while (pulses < 5 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
      if (m_cnt == 0) begin
        pulses++;
        if (pulses == 5) start = 1'b0;
        else begin
          a = 8'd3; b = 8'd1;
        end
      end else begin
        a = 8'($urandom_range(255, 0));
        b = 8'($urandom_range(255, 0));
      end
    end
    start = 1'b0;
    chk_period = 1'b0;
    check("proto_pulses", pulses, 5);
    check("proto_done", 32'(done_a), 32'd1);
    check("proto_product_a", 32'(product_a), 32'd3);
    check("proto_product_x", 32'(product_x), 32'd3);

    // Abort mid-operation with an asynchronous reset between edges.
    @(posedge clk); #1;
    a = 8'd13; b = 8'd11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy_x), 32'd0);
    check("abort_done", 32'(done_x), 32'd0);
    check("abort_product_x", 32'(product_x), 32'd0);
    check("abort_product_a", 32'(product_a), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (N + 2) @(negedge clk);
    check("abort_no_done", 32'(product_x), 32'd0);

    run_op(8'd2, 8'd5);
    check("post_rst_x", 32'(product_x), 32'd10);
    check("post_rst_a", 32'(product_a), 32'd10);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
